// File: rtl/split_stopwatch.sv
// Stopwatch with a BCD mm:ss.cc count, a run/pause prescaler and a wrap pulse.
// Define STOPWATCH_LAP_EN to build the split snapshot (lap / frozen) logic.
module split_stopwatch #(
  parameter int TICK_DIV  = 100000,
  parameter int MIN_LIMIT = 60
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       zero,
  input  logic       lap,
  output logic [3:0] msh,
  output logic [3:0] msl,
  output logic [3:0] sh,
  output logic [3:0] sl,
  output logic [3:0] mh,
  output logic [3:0] ml,
  output logic       frozen,
  output logic       wrap
);
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [3:0]    MIN_LAST_H = 4'((MIN_LIMIT - 1) / 10);
  localparam logic [3:0]    MIN_LAST_L = 4'((MIN_LIMIT - 1) % 10);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    c10ms_q, c10ms_d;
  logic [3:0]    c100ms_q, c100ms_d;
  logic [3:0]    c1s_q, c1s_d;
  logic [3:0]    c10s_q, c10s_d;
  logic [3:0]    c1m_q, c1m_d;
  logic [3:0]    c10m_q, c10m_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  logic [23:0]   live;
  logic [23:0]   disp;

  assign tick = run && (pre_q == PRE_LAST);
  assign live = {c10m_q, c1m_q, c10s_q, c1s_q, c100ms_q, c10ms_q};

  always_comb begin
    pre_d    = pre_q;
    c10ms_d  = c10ms_q;
    c100ms_d = c100ms_q;
    c1s_d    = c1s_q;
    c10s_d   = c10s_q;
    c1m_d    = c1m_q;
    c10m_d   = c10m_q;
    wrap_d   = 1'b0;
    if (zero) begin
      pre_d    = '0;
      c10ms_d  = '0;
      c100ms_d = '0;
      c1s_d    = '0;
      c10s_d   = '0;
      c1m_d    = '0;
      c10m_d   = '0;
    end else if (run) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      // Whole carry chain resolves in one edge: each digit looks only at current state.
      if (tick) begin
        if (c10ms_q != 4'd9) c10ms_d = c10ms_q + 4'd1;
        else begin
          c10ms_d = '0;
          if (c100ms_q != 4'd9) c100ms_d = c100ms_q + 4'd1;
          else begin
            c100ms_d = '0;
            if (c1s_q != 4'd9) c1s_d = c1s_q + 4'd1;
            else begin
              c1s_d = '0;
              if (c10s_q != 4'd5) c10s_d = c10s_q + 4'd1;
              else begin
                c10s_d = '0;
                if (c10m_q == MIN_LAST_H && c1m_q == MIN_LAST_L) begin
                  c1m_d  = '0;
                  c10m_d = '0;
                  wrap_d = 1'b1;
                end else if (c1m_q != 4'd9) c1m_d = c1m_q + 4'd1;
                else begin
                  c1m_d  = '0;
                  c10m_d = c10m_q + 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_q    <= '0;
      c10ms_q  <= '0;
      c100ms_q <= '0;
      c1s_q    <= '0;
      c10s_q   <= '0;
      c1m_q    <= '0;
      c10m_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      c10ms_q  <= c10ms_d;
      c100ms_q <= c100ms_d;
      c1s_q    <= c1s_d;
      c10s_q   <= c10s_d;
      c1m_q    <= c1m_d;
      c10m_q   <= c10m_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [23:0] snap_q, snap_d;
  logic        frz_q, frz_d;

  // Snapshot takes the pre-edge live count, so a coincident tick is not captured.
  always_comb begin
    snap_d = snap_q;
    frz_d  = frz_q;
    if (zero) begin
      snap_d = '0;
      frz_d  = 1'b0;
    end else if (lap) begin
      if (frz_q) frz_d = 1'b0;
      else begin
        snap_d = live;
        frz_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      snap_q <= '0;
      frz_q  <= 1'b0;
    end else begin
      snap_q <= snap_d;
      frz_q  <= frz_d;
    end
  end

  assign disp   = frz_q ? snap_q : live;
  assign frozen = frz_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = live;
  assign frozen     = 1'b0;
`endif

  // msh carries the 10 ms digit and msl the 100 ms digit.
  assign {mh, ml, sh, sl, msl, msh} = disp;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_split_stopwatch.sv
// Bench for split_stopwatch: instance A (TICK_DIV=4, MIN_LIMIT=60), instance B (TICK_DIV=1, MIN_LIMIT=2).
module tb_split_stopwatch;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic       run_a, zero_a, lap_a, run_b, zero_b, lap_b;
  logic [3:0] msh_a, msl_a, sh_a, sl_a, mh_a, ml_a;
  logic [3:0] msh_b, msl_b, sh_b, sl_b, mh_b, ml_b;
  logic       frozen_a, wrap_a, frozen_b, wrap_b;
  logic [23:0] disp_a, disp_b;

  assign disp_a = {mh_a, ml_a, sh_a, sl_a, msl_a, msh_a};
  assign disp_b = {mh_b, ml_b, sh_b, sl_b, msl_b, msh_b};

  split_stopwatch #(.TICK_DIV(4), .MIN_LIMIT(60)) u_a (
    .clk(clk), .clr(clr), .run(run_a), .zero(zero_a), .lap(lap_a),
    .msh(msh_a), .msl(msl_a), .sh(sh_a), .sl(sl_a), .mh(mh_a), .ml(ml_a),
    .frozen(frozen_a), .wrap(wrap_a)
  );

  split_stopwatch #(.TICK_DIV(1), .MIN_LIMIT(2)) u_b (
    .clk(clk), .clr(clr), .run(run_b), .zero(zero_b), .lap(lap_b),
    .msh(msh_b), .msl(msl_b), .sh(sh_b), .sl(sl_b), .mh(mh_b), .ml(ml_b),
    .frozen(frozen_b), .wrap(wrap_b)
  );

  typedef struct {
    string name;
    bit    unit_b;
    int    cs;
    logic  frz;
    logic  wrp;
  } exp_t;

  typedef struct {
    string name;
    logic  run;
    logic  zero;
    int    cycles;
    int    cs;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Expected display for a count of 10 ms units, packed {mh,ml,sh,sl,msl,msh}.
  function automatic logic [23:0] to_digits(int cs);
    logic [3:0] d0, d1, d2, d3, d4, d5;
    d0 = 4'(cs % 10);
    d1 = 4'((cs / 10) % 10);
    d2 = 4'((cs / 100) % 10);
    d3 = 4'((cs / 1000) % 6);
    d4 = 4'((cs / 6000) % 10);
    d5 = 4'(cs / 60000);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic push_exp(string name, bit ub, int cs, logic frz, logic wrp);
    exp_t e;
    e.name   = name;
    e.unit_b = ub;
    e.cs     = cs;
    e.frz    = frz;
    e.wrp    = wrp;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [23:0] got_d, want_d;
    logic        got_f, got_w;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: got no entry, want one expected record");
      return;
    end
    e      = sb.pop_front();
    got_d  = e.unit_b ? disp_b : disp_a;
    got_f  = e.unit_b ? frozen_b : frozen_a;
    got_w  = e.unit_b ? wrap_b : wrap_a;
    want_d = to_digits(e.cs);
    if (got_d === want_d && got_f === e.frz && got_w === e.wrp) n_pass++;
    else $display("FAIL %s: got digits=%h frozen=%b wrap=%b, want digits=%h frozen=%b wrap=%b",
                  e.name, got_d, got_f, got_w, want_d, e.frz, e.wrp);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vt[0] = '{"a_count40",     1'b1, 1'b0, 40, 10};
    vt[1] = '{"a_pause20",     1'b0, 1'b0, 20, 10};
    vt[2] = '{"a_count4",      1'b1, 1'b0,  4, 11};
    vt[3] = '{"a_partial3",    1'b1, 1'b0,  3, 11};
    vt[4] = '{"a_hold5",       1'b0, 1'b0,  5, 11};
    vt[5] = '{"a_resume_tick", 1'b1, 1'b0,  1, 12};
    vt[6] = '{"a_run2",        1'b1, 1'b0,  2, 12};
    vt[7] = '{"a_zero",        1'b1, 1'b1,  1,  0};
    vt[8] = '{"a_presc_clr",   1'b1, 1'b0,  3,  0};
    vt[9] = '{"a_tick_after",  1'b1, 1'b0,  1,  1};

    clr = 1'b0;
    run_a = 1'b1; zero_a = 1'b0; lap_a = 1'b0;
    run_b = 1'b1; zero_b = 1'b0; lap_b = 1'b0;
    #2 clr = 1'b1;

    // Reset held across several edges with run=1
    push_exp("reset_a", 1'b0, 0, 1'b0, 1'b0);
    push_exp("reset_b", 1'b1, 0, 1'b0, 1'b0);
    cycles(3);
    check_pop();
    check_pop();
    run_a = 1'b0;
    run_b = 1'b0;
    clr   = 1'b0;

    // Table-driven count / pause / prescaler hold / zero on instance A
    for (int i = 0; i < 10; i++) begin
      run_a  = vt[i].run;
      zero_a = vt[i].zero;
      push_exp(vt[i].name, 1'b0, vt[i].cs, 1'b0, 1'b0);
      cycles(vt[i].cycles);
      zero_a = 1'b0;
      check_pop();
    end
    run_a = 1'b0;

    // Second and minute carry, then wrap at MIN_LIMIT=2 on instance B
    run_b = 1'b1;
    push_exp("b_0059_99", 1'b1, 5999, 1'b0, 1'b0);
    cycles(5999);
    check_pop();
    push_exp("b_0100_00", 1'b1, 6000, 1'b0, 1'b0);
    cycles(1);
    check_pop();
    push_exp("b_0159_99", 1'b1, 11999, 1'b0, 1'b0);
    cycles(5999);
    check_pop();
    push_exp("b_wrap", 1'b1, 0, 1'b0, 1'b1);
    cycles(1);
    check_pop();
    push_exp("b_post_wrap", 1'b1, 1, 1'b0, 1'b0);
    cycles(1);
    check_pop();

    run_b  = 1'b0;
    zero_b = 1'b1;
    push_exp("b_zero_idle", 1'b1, 0, 1'b0, 1'b0);
    cycles(1);
    zero_b = 1'b0;
    check_pop();

    // Split: lap at live 00:00.37 with a coincident tick, release 100 edges later
    run_b = 1'b1;
    push_exp("b_live37", 1'b1, 37, 1'b0, 1'b0);
    cycles(37);
    check_pop();
    lap_b = 1'b1;
    push_exp("b_lap_freeze", 1'b1, LAP ? 37 : 38, LAP, 1'b0);
    cycles(1);
    lap_b = 1'b0;
    check_pop();
    push_exp("b_frozen_hold", 1'b1, LAP ? 37 : 137, LAP, 1'b0);
    cycles(99);
    check_pop();
    lap_b = 1'b1;
    push_exp("b_lap_release", 1'b1, 138, 1'b0, 1'b0);
    cycles(1);
    lap_b = 1'b0;
    check_pop();
    push_exp("b_live139", 1'b1, 139, 1'b0, 1'b0);
    cycles(1);
    check_pop();

    // Zero beats lap and a wrapping tick on the same edge
    run_b  = 1'b0;
    zero_b = 1'b1;
    cycles(1);
    zero_b = 1'b0;
    run_b  = 1'b1;
    push_exp("b_prio_setup", 1'b1, 11999, 1'b0, 1'b0);
    cycles(11999);
    check_pop();
    zero_b = 1'b1;
    lap_b  = 1'b1;
    push_exp("b_zero_prio", 1'b1, 0, 1'b0, 1'b0);
    cycles(1);
    zero_b = 1'b0;
    lap_b  = 1'b0;
    run_b  = 1'b0;
    check_pop();
    push_exp("b_zero_after", 1'b1, 0, 1'b0, 1'b0);
    cycles(1);
    check_pop();

    // Async clear at 00:12.34 while frozen (lap taken with run=0)
    run_b = 1'b1;
    cycles(1234);
    run_b = 1'b0;
    lap_b = 1'b1;
    run_a = 1'b1;
    push_exp("b_frozen_1234", 1'b1, 1234, LAP, 1'b0);
    cycles(1);
    lap_b = 1'b0;
    check_pop();
    push_exp("a_partial", 1'b0, 1, 1'b0, 1'b0);
    cycles(1);
    check_pop();
    run_a = 1'b0;
    #1 clr = 1'b1;
    push_exp("a_clr_async", 1'b0, 0, 1'b0, 1'b0);
    push_exp("b_clr_async", 1'b1, 0, 1'b0, 1'b0);
    #1;
    check_pop();
    check_pop();
    push_exp("a_clr_held", 1'b0, 0, 1'b0, 1'b0);
    push_exp("b_clr_held", 1'b1, 0, 1'b0, 1'b0);
    cycles(1);
    check_pop();
    check_pop();

    // Resume from prescaler 0 after clear
    clr   = 1'b0;
    run_a = 1'b1;
    run_b = 1'b1;
    push_exp("b_resume", 1'b1, 1, 1'b0, 1'b0);
    push_exp("a_resume1", 1'b0, 0, 1'b0, 1'b0);
    cycles(1);
    check_pop();
    check_pop();
    push_exp("a_resume3", 1'b0, 0, 1'b0, 1'b0);
    cycles(2);
    check_pop();
    push_exp("a_resume4", 1'b0, 1, 1'b0, 1'b0);
    cycles(1);
    check_pop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/split_stopwatch.md
SPLIT_STOPWATCH -- requirements
Module: split_stopwatch

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000: clk cycles per 10 ms tick; legal range 1..2^20.
REQ-002 SHALL have parameter MIN_LIMIT, default 60: minutes modulus; legal range 1..100.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port clr, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port run, input, 1: level; 1 = count, 0 = pause.
REQ-006 SHALL have port zero, input, 1: synchronous clear of the count.
REQ-007 SHALL have port lap, input, 1: single-cycle pulse that toggles split freeze.
REQ-008 SHALL have ports msh, msl, sh, sl, mh, ml, output, 4 each: BCD display digits for 10 ms, 100 ms, 10 s, 1 s, 10 min and 1 min.
REQ-009 SHALL have port frozen, output, 1: display is showing the split snapshot.
REQ-010 SHALL have port wrap, output, 1: one-cycle pulse on full-count rollover.

Function
REQ-011 SHALL keep a prescaler 0..TICK_DIV-1 that advances only while run=1 and holds its value while run=0.
REQ-012 SHALL generate a tick on the cycle where the prescaler is at TICK_DIV-1 and run=1; the prescaler returns to 0 on that cycle.
REQ-013 SHALL, on a tick, increment the live BCD count by one 10 ms unit in the same clock edge (one-edge latency, no ripple).
REQ-014 SHALL carry 10 ms digit 9->0 into the 100 ms digit, 100 ms 9->0 into 1 s, 1 s 9->0 into 10 s, 10 s 5->0 into 1 min, 1 min 9->0 into 10 min.
REQ-015 SHALL treat minutes as a binary-coded decimal value 0..MIN_LIMIT-1; at MIN_LIMIT-1:59.99 a tick yields 00:00.00 and asserts wrap for exactly that cycle.
REQ-016 SHALL never hold a digit outside its legal range (0..9, or 0..5 for sh and the 10 s digit).
REQ-017 SHALL, while frozen=0, drive the display outputs from the live count.
REQ-018 SHALL, while frozen=1, drive the display outputs from the snapshot; the live count keeps running underneath.
REQ-019 SHALL, on lap with frozen=0, load the snapshot with the live count held before that edge and set frozen=1.
REQ-020 SHALL, on lap with frozen=1, clear frozen so the display returns to the live count on the next cycle.
REQ-021 SHALL, when lap and a tick occur on the same edge, capture the pre-increment value.
REQ-022 SHALL give zero priority over run, tick and lap: it clears the count, prescaler, snapshot and frozen, and suppresses wrap.
REQ-023 SHALL accept lap whether run is 0 or 1.

Reset
REQ-024 SHALL, while clr=1, hold all digits, the prescaler and the snapshot at 0, and hold frozen=0 and wrap=0, independent of clk.
REQ-025 SHALL, on clr deassertion, resume counting on the first clk edge with run=1, starting from prescaler 0.
REQ-026 SHALL abort any pending freeze or partially elapsed tick when clr asserts mid-operation.

Configuration
REQ-027 SHALL compile the split snapshot logic only when STOPWATCH_LAP_EN is defined.
REQ-028 SHALL, without STOPWATCH_LAP_EN: ignore lap, tie frozen=0, drive the outputs from the live count, and contain no snapshot registers.

Verification
REQ-029 SHALL test count and pause (TICK_DIV=4): clr, then run=1 for 40 cycles -> display 00:00.10; run=0 for 20 cycles -> unchanged; run=1 for 4 more cycles -> 00:00.11.
REQ-030 SHALL test second carry (TICK_DIV=1): run from 0 for 6000 cycles -> 01:00.00; msl, msh, sl and sh are all 0 and ml=1 on the same edge.
REQ-031 SHALL test wrap (TICK_DIV=1, MIN_LIMIT=2): run 11999 cycles -> 01:59.99; next edge -> 00:00.00, and wrap=1 for one cycle only.
REQ-032 SHALL test split (STOPWATCH_LAP_EN defined, TICK_DIV=1):
- at live 00:00.37, pulse lap -> display holds 00:00.37, frozen=1;
- 100 cycles later, pulse lap -> display shows live 00:01.38, frozen=0.
REQ-033 SHALL test zero priority: zero, lap and a tick on the same edge -> all digits 0, frozen=0, wrap=0.
REQ-034 SHALL test async reset: assert clr between clk edges at 00:12.34 while frozen -> outputs 0 immediately, before the next clk edge.
